// File: rtl/regfile_8x16_if.sv
// Bus bundle for the 8x16 register file: one write port, two registered
// read ports, clear request and busy status.
interface regfile_8x16_if;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic        clr;
    logic        busy;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, clr,
        input  rdata_a, rdata_b, busy
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, clr,
        output rdata_a, rdata_b, busy
    );
endinterface

// File: rtl/regfile_8x16.sv
// 8x16 register file, two registered read ports, one write port and a
// sequential clear engine. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_8x16 #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input logic           clk,
    input logic           rst_n,
    regfile_8x16_if.slave bus
);
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_en_c;
    logic [DW-1:0] rd_a_c;
    logic [DW-1:0] rd_b_c;

    // A write is accepted only in IDLE and loses to a simultaneous clear
    assign wr_en_c = (state == IDLE) && bus.we && !bus.clr;

    always_comb begin
        rd_a_c = mem[bus.raddr_a];
        rd_b_c = mem[bus.raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_en_c && (bus.waddr == bus.raddr_a)) rd_a_c = bus.wdata;
        if (wr_en_c && (bus.waddr == bus.raddr_b)) rd_b_c = bus.wdata;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
            state       <= IDLE;
            ptr         <= '0;
            bus.busy    <= 1'b0;
            bus.rdata_a <= RESET_VALUE;
            bus.rdata_b <= RESET_VALUE;
        end else begin
            bus.rdata_a <= rd_a_c;
            bus.rdata_b <= rd_b_c;
            case (state)
                IDLE: begin
                    if (bus.clr) begin
                        state    <= CLEAR;
                        ptr      <= '0;
                        bus.busy <= 1'b1;
                    end else if (bus.we) begin
                        mem[bus.waddr] <= bus.wdata;
                    end
                end
                CLEAR: begin
                    // One register per cycle; the last one returns to IDLE
                    mem[ptr] <= RESET_VALUE;
                    ptr      <= ptr + AW'(1);
                    if (ptr == AW'(DEPTH - 1)) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/regfile_8x16.md
REGFILE_8X16 -- requirements
Module: regfile_8x16

Interface
REQ-001 Parameter: RESET_VALUE, default 16'h0000, value loaded into every register on reset and on clear.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: we  input  1  write enable for the write port.
REQ-005 Port: waddr  input  3  write address.
REQ-006 Port: wdata  input  16  write data; carries the 16-bit bitwise-OR result back into the file.
REQ-007 Port: raddr_a  input  3  read address, port A.
REQ-008 Port: raddr_b  input  3  read address, port B.
REQ-009 Port: rdata_a  output  16  registered read data, port A; drives the a operand of the 16-bit OR stage.
REQ-010 Port: rdata_b  output  16  registered read data, port B; drives the b operand of the 16-bit OR stage.
REQ-011 Port: clr  input  1  clear request; pulse or level.
REQ-012 Port: busy  output  1  high while a clear sequence runs.

Function
REQ-013 Storage SHALL be 8 registers x 16 bits.
REQ-014 Reads SHALL be registered: rdata_x SHALL be valid in cycle N+1 for raddr_x sampled at the edge that ends cycle N (1-cycle latency, both ports independent).
REQ-015 raddr_a == raddr_b SHALL return identical data on both ports.
REQ-016 A write SHALL occur at the rising edge when we=1 and the FSM is in IDLE; reg[waddr] <= wdata.
REQ-017 The FSM SHALL have two states: IDLE and CLEAR.
REQ-018 IDLE -> CLEAR SHALL happen at the edge where clr=1; the 3-bit clear pointer loads 0.
REQ-019 In CLEAR, one register per cycle SHALL be set to RESET_VALUE: reg[ptr] <= RESET_VALUE, ptr <= ptr+1, starting at reg0.
REQ-020 CLEAR -> IDLE SHALL happen at the edge that clears reg7 (8 cycles total); ptr wraps to 0.
REQ-021 busy SHALL be 1 exactly while the state is CLEAR (registered, 8 cycles per clear).
REQ-022 In CLEAR, we SHALL be ignored (write dropped, no queuing); reads SHALL continue and return current contents, cleared or not.
REQ-023 clr asserted while in CLEAR SHALL be ignored (no restart); clr held high through CLEAR SHALL start a new clear on the first IDLE cycle it is still sampled high.
REQ-024 clr=1 and we=1 at the same IDLE edge: the write SHALL be dropped and the clear SHALL start.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, set all 8 registers to RESET_VALUE, rdata_a=rdata_b=RESET_VALUE, state=IDLE, ptr=0, busy=0.
REQ-026 Reset asserted mid-CLEAR SHALL abort the sequence; after release the block SHALL be in IDLE with busy=0.
REQ-027 The first active edge after rst_n rises SHALL behave as a normal IDLE cycle.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-029 With REGFILE_BYPASS_EN defined: a read of address X at the same edge as an accepted write to X SHALL return wdata next cycle.
REQ-030 Without REGFILE_BYPASS_EN: the same case SHALL return the old contents of X next cycle; the new value is visible from the following read onward.
REQ-031 Forwarding SHALL never apply to dropped writes (CLEAR state or REQ-024).

Verification
REQ-032 Reset -> rdata_a=rdata_b=16'h0000, busy=0 asynchronously before any clock edge.
REQ-033 Write reg3=16'hA5A5, reg5=16'h0F0F; read raddr_a=3, raddr_b=5 -> next cycle rdata_a=16'hA5A5, rdata_b=16'h0F0F.
REQ-034 Same-edge write reg2=16'h1234 and read raddr_a=2 (reg2 previously 0) -> rdata_a=16'h1234 with REGFILE_BYPASS_EN, 16'h0000 without.
REQ-035 Fill all regs with 16'hFFFF, pulse clr -> busy high 8 cycles; reg0..reg7 read 0 one per cycle in order; write of 16'h5555 to reg7 at cycle 3 of CLEAR dropped (reg7 reads 0 afterwards).
REQ-036 Assert rst_n=0 at cycle 4 of CLEAR with regs 4..7 = 16'hFFFF -> all regs 0, busy=0 immediately; clr+we same IDLE edge to reg1=16'h00FF -> reg1 reads 0, busy=1 next cycle.
